mem_responder: RTL and testbench

- Memory-side responder for the microprogrammed control unit's memory handshake.
- Latches the address from the shared 8-bit bus on MAR_in.
- Performs a read or write when the CU requests one (WMFC with rnw), after a programmable number of wait states.
- Holds MFC high until the CU drops its request, so the CU's MFC-gated clock can advance.
- Sits between the CU/datapath bus and the storage array.

---
 rtl/mem_pkg.sv | 8 +
 rtl/mem_array.sv | 19 +
 rtl/mem_responder.sv | 83 ++++++++
 tb/tb_mem_responder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM states, default widths and access encodings for mem_responder
package mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;
    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;
endpackage

// File: rtl/mem_array.sv
// mem_array: 2**AW x DW storage, combinational read, synchronous write, no reset
module mem_array #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    // write port; contents survive reset
    always_ff @(posedge CLK)
        if (we) mem[addr] <= wdata;

    assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: CU memory handshake responder (MAR/MBR, wait states, MFC); MAR_AUTOINC_EN adds MAR post-increment
module mem_responder
    import mem_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF,
    parameter int LAT = 2
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [DW-1:0] bus_in,
    input  logic          MAR_in,
    input  logic          MBR_in,
    input  logic          MBR_out,
    input  logic          WMFC,
    input  logic          rnw,
    output logic [DW-1:0] bus_out,
    output logic          bus_oe,
    output logic          MFC,
    output logic          busy
);
    localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    state_t        state;
    logic [AW-1:0] mar;
    logic [DW-1:0] mbr;
    logic [CW-1:0] cnt;
    logic          op;
    logic [DW-1:0] rdata;
    logic          fire;

    // the access happens on the last WAIT cycle, once the wait count is exhausted
    assign fire = (state == WAIT) && (cnt == '0);

    mem_array #(.AW(AW), .DW(DW)) u_mem (
        .CLK   (CLK),
        .we    (fire && (op == WR)),
        .addr  (mar),
        .wdata (mbr),
        .rdata (rdata)
    );

    // handshake FSM with MAR/MBR and wait counter; loads only accepted while idle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            mar   <= '0;
            mbr   <= '0;
            cnt   <= '0;
            op    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MAR_in) mar <= AW'(bus_in);
                    if (MBR_in) mbr <= bus_in;
                    if (WMFC) begin
                        op    <= rnw;
                        cnt   <= CW'(LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        if (op == RD) mbr <= rdata;
`ifdef MAR_AUTOINC_EN
                        mar <= mar + AW'(1);
`endif
                        state <= DONE;
                    end
                end
                DONE:    if (!WMFC) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign MFC     = (state == DONE);
    assign busy    = (state != IDLE);
    assign bus_out = mbr;
    assign bus_oe  = MBR_out;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for mem_responder (LAT=2 and LAT=0 instances)
module tb_mem_responder;
  localparam int LAT_A = 2;
  localparam int LAT_B = 0;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] a_bus = '0, b_bus = '0;
  logic       a_mar_in = 0, a_mbr_in = 0, a_mbr_out = 0, a_wmfc = 0, a_rnw = 0;
  logic       b_mar_in = 0, b_mbr_in = 0, b_mbr_out = 0, b_wmfc = 0, b_rnw = 0;
  logic [7:0] a_bus_out, b_bus_out;
  logic       a_oe, a_mfc, a_busy, b_oe, b_mfc, b_busy;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] model [256];
  logic [7:0] sb [$];
  logic [7:0] exp_d;
  always #5 CLK = ~CLK;
  mem_responder #(.AW(8), .DW(8), .LAT(LAT_A)) u_a (
    .CLK(CLK), .RST_N(RST_N), .bus_in(a_bus), .MAR_in(a_mar_in), .MBR_in(a_mbr_in),
    .MBR_out(a_mbr_out), .WMFC(a_wmfc), .rnw(a_rnw), .bus_out(a_bus_out),
    .bus_oe(a_oe), .MFC(a_mfc), .busy(a_busy)
  );
  mem_responder #(.AW(8), .DW(8), .LAT(LAT_B)) u_b (
    .CLK(CLK), .RST_N(RST_N), .bus_in(b_bus), .MAR_in(b_mar_in), .MBR_in(b_mbr_in),
    .MBR_out(b_mbr_out), .WMFC(b_wmfc), .rnw(b_rnw), .bus_out(b_bus_out),
    .bus_oe(b_oe), .MFC(b_mfc), .busy(b_busy)
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    if (o !== e) begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic a_req(input logic rd, input logic [7:0] addr, input bit load, input logic [7:0] data);
    if (load) begin
      a_bus = addr; a_mar_in = 1; tick(); a_mar_in = 0;
    end
    if (!rd) begin
      a_bus = data; a_mbr_in = 1; tick(); a_mbr_in = 0;
    end
    if (rd) sb.push_back(model[addr]);
    a_wmfc = 1; a_rnw = rd;
  endtask
  task automatic a_wait(input logic rd, input int exp_edges);
    int e = 0;
    while (a_mfc !== 1'b1 && e < 50) begin tick(); e++; end
    chk("a_timeout", e < 50, 1);
    chk("a_latency", e, exp_edges);
    chk("a_busy_done", a_busy, 1'b1);
    if (rd) begin
      chk("a_sb_depth", sb.size(), 1);
      if (sb.size() > 0) begin
        exp_d = sb.pop_front();
        chk("a_rdata", a_bus_out, exp_d);
      end
    end
  endtask
  task automatic a_op(input logic rd, input logic [7:0] addr, input bit load, input logic [7:0] data);
    a_req(rd, addr, load, data);
    a_wait(rd, LAT_A + 2);
    if (!rd) model[addr] = data;
    a_wmfc = 0;
    tick();
    chk("a_mfc_release", a_mfc, 1'b0);
    chk("a_busy_release", a_busy, 1'b0);
  endtask
  initial begin
    tick();
    chk("rst_mfc", a_mfc, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_mbr", a_bus_out, 8'h00);
    chk("rst_mar", u_a.mar, 8'h00);
    chk("rst_oe", a_oe, 1'b0);
    RST_N = 1;
    tick();
    a_op(0, 8'h3C, 1, 8'hA5);
    a_mbr_out = 1;
    #1;
    chk("a_oe_on", a_oe, 1'b1);
    a_op(1, 8'h3C, 1, 8'h00);
    chk("a_bus_hold", a_bus_out, 8'hA5);
    a_req(1, 8'h3C, 1, 8'h00);
    a_wait(1, LAT_A + 2);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_mfc", a_mfc, 1'b1);
      chk("hold_busy", a_busy, 1'b1);
    end
    a_wmfc = 0;
    tick();
    chk("hold_drop_mfc", a_mfc, 1'b0);
    chk("hold_drop_busy", a_busy, 1'b0);
    a_req(0, 8'h20, 1, 8'h5A);
    tick();
    a_bus = 8'hFF; a_mar_in = 1; a_mbr_in = 1;
    tick();
    a_mar_in = 0; a_mbr_in = 0;
    chk("busy_mar", u_a.mar, 8'h20);
    chk("busy_mbr", a_bus_out, 8'h5A);
    a_wait(0, LAT_A);
    model[8'h20] = 8'h5A;
    a_wmfc = 0;
    tick();
    a_op(1, 8'h20, 1, 8'h00);
    b_bus = 8'h44; b_mar_in = 1; tick(); b_mar_in = 0;
    b_bus = 8'h99; b_mbr_in = 1; tick(); b_mbr_in = 0;
    b_wmfc = 1; b_rnw = 0;
    tick();
    tick();
    chk("b_wr_mfc", b_mfc, 1'b1);
    model[8'h44] = 8'h99;
    b_wmfc = 0;
    tick();
    b_bus = 8'h00; b_mbr_in = 1; tick(); b_mbr_in = 0;
    chk("b_mbr_cleared", b_bus_out, 8'h00);
    sb.push_back(model[8'h44]);
    b_bus = 8'h44; b_mar_in = 1; b_wmfc = 1; b_rnw = 1;
    tick();
    b_mar_in = 0; b_wmfc = 0;
    chk("b_wait_mfc", b_mfc, 1'b0);
    chk("b_wait_busy", b_busy, 1'b1);
    tick();
    chk("b_pulse_mfc", b_mfc, 1'b1);
    chk("b_sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      exp_d = sb.pop_front();
      chk("b_rdata", b_bus_out, exp_d);
    end
    tick();
    chk("b_pulse_end", b_mfc, 1'b0);
    chk("b_idle", b_busy, 1'b0);
    a_op(0, 8'h10, 1, 8'h11);
    a_req(0, 8'h10, 1, 8'h77);
    tick();
    chk("mid_busy", a_busy, 1'b1);
    #2 RST_N = 0;
    #1;
    chk("mid_rst_mfc", a_mfc, 1'b0);
    chk("mid_rst_busy", a_busy, 1'b0);
    chk("mid_rst_mar", u_a.mar, 8'h00);
    chk("mid_rst_mbr", a_bus_out, 8'h00);
    a_wmfc = 0;
    tick();
    tick();
    RST_N = 1;
    tick();
    a_op(1, 8'h10, 1, 8'h00);
`ifdef MAR_AUTOINC_EN
    a_op(0, 8'hFF, 1, 8'hE1);
    chk("inc_wrap", u_a.mar, 8'h00);
    a_op(0, 8'h00, 1, 8'h1E);
    a_op(1, 8'hFF, 1, 8'h00);
    a_op(1, 8'h00, 0, 8'h00);
`else
    a_op(0, 8'hFF, 1, 8'hE1);
    chk("mar_hold", u_a.mar, 8'hFF);
    a_op(1, 8'hFF, 0, 8'h00);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
